// File: rtl/wb_warmboot_ctl.sv
// wb_warmboot_ctl: Wishbone slot-0 slave that gates the dfu_helper warm-boot request behind a key,
// a programmable countdown and an abort path. Optional macro WARMBOOT_BTN_ABORT_EN adds a button abort.
module wb_warmboot_ctl #(
  parameter int                     DELAY_WIDTH = 24,
  parameter logic [DELAY_WIDTH-1:0] DELAY_RESET = 24'd240000,
  parameter logic [31:0]            KEY         = 32'hB007CAFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
`ifdef WARMBOOT_BTN_ABORT_EN
  input  logic        btn_abort,
`endif
  output logic        boot_now,
  output logic [1:0]  boot_sel,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_BOOT  = 2'd3
  } state_t;

  localparam int                     PAD_W   = 32 - DELAY_WIDTH;
  localparam logic [DELAY_WIDTH-1:0] CNT_ONE = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r, state_n;
  logic [DELAY_WIDTH-1:0] delay_r, delay_n;
  logic [DELAY_WIDTH-1:0] count_r, count_n;
  logic [1:0]             boot_sel_r, sel_n;
  logic                   boot_now_r, boot_now_n;
  logic                   cyc_q_r;
  logic                   ack_r;
  logic [31:0]            rdata_r;
  logic [31:0]            rd_s;

  logic acc_s, wr_s, csr_wr_s, key_wr_s, delay_wr_s;
  logic abort_s, go_s, key_ok_s, key_bad_s, cfg_open_s;
  logic btn_evt_s, btn_flag_s;

  // One access per rising edge of wb_cyc; the ack register blocks a second strobe.
  assign acc_s      = wb_cyc & ~cyc_q_r & ~ack_r;
  assign wr_s       = acc_s & wb_we;
  assign csr_wr_s   = wr_s & (wb_addr == 2'd0);
  assign key_wr_s   = wr_s & (wb_addr == 2'd1);
  assign delay_wr_s = wr_s & (wb_addr == 2'd2);
  assign abort_s    = csr_wr_s & wb_wdata[3];
  assign go_s       = csr_wr_s & wb_wdata[2] & ~wb_wdata[3];
  assign cfg_open_s = (state_r == ST_IDLE) || (state_r == ST_ARMED);
  assign key_ok_s   = key_wr_s & (wb_wdata == KEY) & cfg_open_s;
  assign key_bad_s  = key_wr_s & (wb_wdata != KEY);

`ifdef WARMBOOT_BTN_ABORT_EN
  logic btn_meta_r, btn_sync_r, btn_prev_r, btn_flag_r;

  assign btn_evt_s  = btn_sync_r & ~btn_prev_r &
                      ((state_r == ST_ARMED) || (state_r == ST_COUNT));
  assign btn_flag_s = btn_flag_r;

  // Button synchronizer, edge detect and sticky aborted-by-button flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
      btn_prev_r <= 1'b0;
      btn_flag_r <= 1'b0;
    end else begin
      btn_meta_r <= btn_abort;
      btn_sync_r <= btn_meta_r;
      btn_prev_r <= btn_sync_r;
      if (btn_evt_s) begin
        btn_flag_r <= 1'b1;
      end else if (key_ok_s) begin
        btn_flag_r <= 1'b0;
      end else begin
        btn_flag_r <= btn_flag_r;
      end
    end
  end
`else
  assign btn_evt_s  = 1'b0;
  assign btn_flag_s = 1'b0;
`endif

  // Next-state logic for the boot sequencer and its configuration registers.
  always_comb begin
    state_n = state_r;
    count_n = count_r;
    case (state_r)
      ST_IDLE: begin
        if (key_ok_s) begin
          state_n = ST_ARMED;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (abort_s || key_bad_s || btn_evt_s) begin
          state_n = ST_IDLE;
        end else if (go_s) begin
          state_n = ST_COUNT;
          count_n = delay_r;
        end else begin
          state_n = ST_ARMED;
        end
      end
      ST_COUNT: begin
        if (abort_s || btn_evt_s) begin
          state_n = ST_IDLE;
          count_n = {DELAY_WIDTH{1'b0}};
        end else if (count_r == {DELAY_WIDTH{1'b0}}) begin
          state_n = ST_BOOT;
        end else begin
          count_n = count_r - CNT_ONE;
        end
      end
      ST_BOOT: begin
        state_n = ST_BOOT;
      end
      default: begin
        state_n = ST_IDLE;
        count_n = {DELAY_WIDTH{1'b0}};
      end
    endcase

    // boot_sel and DELAY are frozen once the countdown has started.
    if (csr_wr_s && cfg_open_s) begin
      sel_n = wb_wdata[1:0];
    end else begin
      sel_n = boot_sel_r;
    end
    if (delay_wr_s && cfg_open_s) begin
      delay_n = wb_wdata[DELAY_WIDTH-1:0];
    end else begin
      delay_n = delay_r;
    end
    boot_now_n = boot_now_r | (state_n == ST_BOOT);
  end

  // Register read multiplexer, sampled into rdata_r on the ack cycle.
  always_comb begin
    rd_s = 32'd0;
    case (wb_addr)
      2'd0:    rd_s = {26'd0, btn_flag_s, boot_now_r, state_r, boot_sel_r};
      2'd1:    rd_s = {31'd0, (state_r != ST_IDLE)};
      2'd2:    rd_s = {{PAD_W{1'b0}}, delay_r};
      2'd3:    rd_s = {{PAD_W{1'b0}}, count_r};
      default: rd_s = 32'd0;
    endcase
  end

  // State, configuration and bus response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      delay_r    <= DELAY_RESET;
      count_r    <= {DELAY_WIDTH{1'b0}};
      boot_sel_r <= 2'd0;
      boot_now_r <= 1'b0;
      cyc_q_r    <= 1'b0;
      ack_r      <= 1'b0;
      rdata_r    <= 32'd0;
    end else begin
      state_r    <= state_n;
      delay_r    <= delay_n;
      count_r    <= count_n;
      boot_sel_r <= sel_n;
      boot_now_r <= boot_now_n;
      cyc_q_r    <= wb_cyc;
      ack_r      <= acc_s;
      rdata_r    <= (acc_s && !wb_we) ? rd_s : 32'd0;
    end
  end

  assign wb_ack   = ack_r;
  assign wb_rdata = rdata_r;
  assign boot_now = boot_now_r;
  assign boot_sel = boot_sel_r;
  assign busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_wb_warmboot_ctl.sv
// Scoreboard bench for wb_warmboot_ctl; expected read data is queued at drive time and popped on ack.
module tb_wb_warmboot_ctl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;
  logic        boot_now;
  logic [1:0]  boot_sel;
  logic        busy;
`ifdef WARMBOOT_BTN_ABORT_EN
  logic        btn_abort;
`endif

  wb_warmboot_ctl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_addr  (wb_addr),
    .wb_wdata (wb_wdata),
    .wb_rdata (wb_rdata),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack),
`ifdef WARMBOOT_BTN_ABORT_EN
    .btn_abort(btn_abort),
`endif
    .boot_now (boot_now),
    .boot_sel (boot_sel),
    .busy     (busy)
  );

  localparam logic [31:0] KEY_OK = 32'hB007CAFE;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  edge_n = 0;
  int  last_cap = 0;
  int  boot_edge = 0;
  bit  boot_seen = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n = edge_n + 1;

  // Record the edge on which boot_now first rises after each reset.
  always @(negedge clk) begin
    if (boot_now && !boot_seen) begin
      boot_seen = 1'b1;
      boot_edge = edge_n;
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n, input int g, input int cap);
    int k;
    k = cap - 1 - g;
    return (k >= n) ? 32'd0 : 32'(n - k);
  endfunction

  task automatic bus_xfer(input bit we, input logic [1:0] addr, input logic [31:0] data,
                          input logic [31:0] exp, input bit cnt_mode, input int cnt_n,
                          input int cnt_g, input string tag);
    sb_t ent;
    @(negedge clk);
    wb_cyc   = 1'b1;
    wb_we    = we;
    wb_addr  = addr;
    wb_wdata = data;
    last_cap = edge_n + 1;
    ent.rd   = !we;
    ent.exp  = cnt_mode ? exp_cnt(cnt_n, cnt_g, last_cap) : exp;
    ent.tag  = tag;
    sb_q.push_back(ent);
    @(negedge clk);
    chk_val({tag, "_ack"}, 32'(wb_ack), 32'd1);
    if (wb_ack) begin
      ent = sb_q.pop_front();
      if (ent.rd) chk_val(ent.tag, wb_rdata, ent.exp);
    end
    @(negedge clk);
    chk_val({tag, "_ack_once"}, 32'(wb_ack), 32'd0);
    chk_val({tag, "_rdata_idle"}, wb_rdata, 32'd0);
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data, input string tag);
    bus_xfer(1'b1, addr, data, 32'd0, 1'b0, 0, 0, tag);
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string tag);
    bus_xfer(1'b0, addr, 32'd0, exp, 1'b0, 0, 0, tag);
  endtask

  task automatic rd_cnt(input int n, input int g, input string tag);
    bus_xfer(1'b0, 2'd3, 32'd0, 32'd0, 1'b1, n, g, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    boot_seen = 1'b0;
    sb_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    rst_n    = 1'b0;
    wb_addr  = 2'd0;
    wb_wdata = 32'd0;
    wb_we    = 1'b0;
    wb_cyc   = 1'b0;
`ifdef WARMBOOT_BTN_ABORT_EN
    btn_abort = 1'b0;
`endif

    // Reset values and plain reads
    do_reset();
    chk_val("rst_ack", 32'(wb_ack), 32'd0);
    chk_val("rst_rdata", wb_rdata, 32'd0);
    chk_val("rst_boot_now", 32'(boot_now), 32'd0);
    chk_val("rst_boot_sel", 32'(boot_sel), 32'd0);
    chk_val("rst_busy", 32'(busy), 32'd0);
    rd(2'd0, 32'd0, "t1_csr");
    rd(2'd2, 32'd240000, "t1_delay");
    rd(2'd3, 32'd0, "t1_count");
    rd(2'd1, 32'd0, "t1_key");

    // go without key is ignored, sel still updates in IDLE
    wr(2'd0, 32'h6, "t2_go");
    rd(2'd0, 32'h2, "t2_csr");
    chk_val("t2_boot_now", 32'(boot_now), 32'd0);
    chk_val("t2_boot_sel", 32'(boot_sel), 32'd2);
    chk_val("t2_busy", 32'(busy), 32'd0);

    // Full boot with DELAY=5
    wr(2'd1, KEY_OK, "t3_key");
    rd(2'd1, 32'd1, "t3_armed");
    chk_val("t3_busy", 32'(busy), 32'd1);
    wr(2'd0, 32'h3, "t3_sel");
    rd(2'd0, 32'h7, "t3_csr_armed");
    wr(2'd2, 32'd5, "t3_delay");
    rd(2'd2, 32'd5, "t3_delay_rb");
    wr(2'd0, 32'h5, "t3_go");
    g = last_cap;
    for (int i = 0; i < 4; i++) rd_cnt(5, g, "t3_count");
    chk_val("t3_boot_seen", 32'(boot_seen), 32'd1);
    chk_val("t3_boot_edge", 32'(boot_edge), 32'(g + 6));
    rd(2'd0, 32'h1D, "t3_csr_boot");
    chk_val("t3_boot_sel", 32'(boot_sel), 32'd1);
    wr(2'd1, 32'h0, "t3_key_bad");
    wr(2'd0, 32'h8, "t3_abort");
    wr(2'd2, 32'd9, "t3_delay_ign");
    rd(2'd0, 32'h1D, "t3_csr_sticky");
    rd(2'd2, 32'd5, "t3_delay_kept");
    chk_val("t3_boot_now", 32'(boot_now), 32'd1);

    // Abort mid-count
    do_reset();
    wr(2'd1, KEY_OK, "t4_key");
    wr(2'd2, 32'd100, "t4_delay");
    wr(2'd0, 32'h4, "t4_go");
    g = last_cap;
    wr(2'd2, 32'd7, "t4_delay_ign");
    rd(2'd2, 32'd100, "t4_delay_kept");
    rd_cnt(100, g, "t4_count");
    wr(2'd0, 32'h3, "t4_sel_frozen");
    repeat (20) @(negedge clk);
    wr(2'd0, 32'h8, "t4_abort");
    rd(2'd0, 32'h0, "t4_csr");
    rd(2'd1, 32'd0, "t4_key_rd");
    rd(2'd3, 32'd0, "t4_count_clr");
    chk_val("t4_no_boot", 32'(boot_seen), 32'd0);
    chk_val("t4_busy", 32'(busy), 32'd0);

    // Wrong key disarms; go+abort at DELAY=0; then DELAY=0 boots next cycle
    do_reset();
    wr(2'd1, KEY_OK, "t5_key");
    wr(2'd1, 32'h12345678, "t5_key_bad");
    rd(2'd1, 32'd0, "t5_disarmed");
    wr(2'd0, 32'h4, "t5_go_ign");
    rd(2'd0, 32'h0, "t5_csr_idle");
    wr(2'd1, KEY_OK, "t5_key2");
    wr(2'd2, 32'd0, "t5_delay0");
    wr(2'd0, 32'hC, "t5_go_abort");
    rd(2'd0, 32'h0, "t5_csr_abort");
    repeat (10) @(negedge clk);
    chk_val("t5_no_boot", 32'(boot_seen), 32'd0);
    wr(2'd1, KEY_OK, "t5_key3");
    wr(2'd0, 32'h7, "t5_go0");
    g = last_cap;
    repeat (4) @(negedge clk);
    chk_val("t5_boot_edge", 32'(boot_edge), 32'(g + 1));
    rd(2'd0, 32'h1F, "t5_csr_boot");

    // Asynchronous reset during COUNT
    do_reset();
    wr(2'd1, KEY_OK, "t7_key");
    wr(2'd2, 32'd50, "t7_delay");
    wr(2'd0, 32'h6, "t7_go");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_val("t7_busy", 32'(busy), 32'd0);
    chk_val("t7_boot_now", 32'(boot_now), 32'd0);
    chk_val("t7_boot_sel", 32'(boot_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(2'd0, 32'h0, "t7_csr");
    rd(2'd2, 32'd240000, "t7_delay");
    repeat (60) @(negedge clk);
    chk_val("t7_no_boot", 32'(boot_seen), 32'd0);

`ifdef WARMBOOT_BTN_ABORT_EN
    // Button abort during COUNT
    do_reset();
    wr(2'd1, KEY_OK, "t6_key");
    wr(2'd2, 32'd1000, "t6_delay");
    wr(2'd0, 32'h4, "t6_go");
    repeat (50) @(negedge clk);
    btn_abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_val("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    btn_abort = 1'b0;
    rd(2'd0, 32'h20, "t6_csr_flag");
    wr(2'd1, KEY_OK, "t6_key_clr");
    rd(2'd0, 32'h04, "t6_csr_clr");
`endif

    chk_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
